multi_clock_divider: RTL
========================

# multi_clock_divider

Multi-channel, runtime-reconfigurable clock divider that generates several square-wave enables and matching one-cycle tick strobes from the 100 MHz system clock. It is the parametrised successor to the fixed 1 kHz divider. Its channels feed the reaction-timer millisecond base, display multiplexing and LED blink timing. Each channel has its own half-period divisor, which can be reloaded glitch-free through a valid/ready port, plus an individual enable.

## Interface
- NUM_CH, 4: number of independent channels (≥1).
- CNT_W, 17: width of the per-channel counter and divisor.
- DEFAULT_DIV, 50000: half-period divisor loaded at reset. 50000 gives 1 kHz from 100 MHz. Must be in the range 1..2^CNT_W−1.
- CH_W, derived: max(1, ceil(log2(NUM_CH))).

Ports:
- clk_100MHz  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  divisor update request.
- cfg_ch  in  CH_W  target channel of the update.
- cfg_div  in  CNT_W  new half-period divisor, in clock cycles.
- cfg_ready  out  1  update can be accepted this cycle.
- clk_out  out  NUM_CH  divided square wave, period 2×div cycles, 50% duty.
- tick  out  NUM_CH  one-cycle strobe on every 0→1 transition of clk_out.

## Operation
Per-channel state:
- count[CNT_W]
- div_act[CNT_W]
- div_pend[CNT_W]
- pend flag
- clk_out and tick registers

Reset (rst=1 at an edge, regardless of any other input, including mid-period):
- count=0, clk_out=0, tick=0, pend=0, div_act=DEFAULT_DIV.
- cfg_ready reads 1 after reset.

Enabled channel (ch_en[i]=1), at each edge:
- If count == div_act−1: count←0 and clk_out toggles.
  - tick←1 if the toggle is 0→1, else tick←0.
  - If pend=1: div_act←div_pend and pend←0 (the new divisor applies from the next half-period).
- Otherwise: count←count+1, tick←0.

Disabled channel (ch_en[i]=0), at each edge:
- count←0, clk_out←0, tick←0.
- If pend=1: div_act←div_pend and pend←0 immediately.

Configuration handshake:
- cfg_ready = (cfg_ch < NUM_CH) & ~pend[cfg_ch]. This is combinational from cfg_ch and registered state.
- Accept occurs when cfg_valid & cfg_ready at an edge. On accept: div_pend[cfg_ch]←cfg_div and pend[cfg_ch]←1.
- cfg_div=0 is clamped to 1 on accept.
- A request that is not accepted is ignored. The source must hold it until cfg_ready.
- If an accept and a half-period boundary occur on the same channel in the same edge, the boundary uses the old pending state. The newly accepted value waits for the next boundary.

Arithmetic and phase:
- The counter compares equal against div_act−1 and never wraps past it.
- div_act=1 toggles clk_out every cycle (50 MHz).
- Channels are independent. Channels enabled on the same edge with equal divisors stay phase-aligned.

## Timing
- ch_en rises before edge E0, with div_act=D:
  - clk_out first goes to 1 at edge E0+D−1 (visible after the D-th enabled edge), with tick=1 in that same cycle.
  - clk_out returns to 0 D cycles later.
- tick is high for exactly 1 cycle per full period. It rises on the same edge as clk_out.
- Latency from cfg accept to the new divisor taking effect:
  - enabled channel: the end of the current half-period;
  - disabled channel: 1 cycle.
- Deasserting ch_en forces clk_out=0 at the next edge, even mid-high-phase. Re-enabling restarts from count 0 with a full first half-period.
- All outputs are registered except cfg_ready.

## Test plan
Bench parameters: NUM_CH=3, CNT_W=8, DEFAULT_DIV=4.

1. Reset, then ch_en=3'b111 for 40 cycles. Expected: every clk_out has period 8 and duty 4/4; first rise on the 4th enabled edge; tick high 1 cycle per 8; all three channels aligned.
2. Channel 1 running. Accept cfg_ch=1, cfg_div=2 mid-high-phase. Expected:
   - the current half-period completes at 4 cycles, then the period becomes 4;
   - cfg_ready for ch1 is 0 from the accept until the boundary;
   - a second request to ch1 in that window is ignored.
3. Accept on the exact boundary edge, cfg_div=6. Expected: the next half-period is still 4; the one after is 6.
4. cfg_div=0 on ch0. Expected: treated as 1; clk_out toggles every cycle; tick every 2 cycles.
5. cfg_ch=3. Expected: cfg_ready=0 and no state changes. Drop ch_en[2] while clk_out[2]=1. Expected: clk_out[2]=0 the next cycle; re-enabling gives the first rise after 4 edges.
6. Assert rst mid-period with a pending update. Expected: all outputs 0, pend cleared, div_act=4, cfg_ready=1 the following cycle.

Source files
------------

// File: rtl/multi_clock_divider_if.sv
// Divisor-update handshake between a configuration source and multi_clock_divider.
interface multi_clock_divider_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 17
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             cfg_valid;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_ready;

   modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel clock divider: per-channel 50% square wave plus rising-edge tick,
// with a half-period divisor that is reloaded glitch-free at half-period boundaries.
// Each channel runs a down-counter that reloads with (divisor - 1) and toggles
// clk_out when it reaches zero.
module multi_clock_divider #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 17,
   parameter int DEFAULT_DIV = 50000
) (
   input  logic                 clk_100MHz,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    ch_en,
   multi_clock_divider_if.slave cfg,
   output logic [NUM_CH-1:0]    clk_out,
   output logic [NUM_CH-1:0]    tick
);
   localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DEFAULT_DIV - 1);

   logic [CNT_W-1:0]  cnt_q      [NUM_CH];
   logic [CNT_W-1:0]  cnt_d      [NUM_CH];
   logic [CNT_W-1:0]  div_act_q  [NUM_CH];
   logic [CNT_W-1:0]  div_act_d  [NUM_CH];
   logic [CNT_W-1:0]  div_pend_q [NUM_CH];
   logic [CNT_W-1:0]  div_pend_d [NUM_CH];
   logic [CNT_W-1:0]  div_next   [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] clk_q, clk_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic              cfg_ready_c;
   logic              accept;
   logic [CNT_W-1:0]  div_in;

   // Ready only for an existing channel that has no update already waiting.
   always_comb begin
      cfg_ready_c = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg.cfg_ch == CH_W'(i)) cfg_ready_c = ~pend_q[i];
      end
   end

   assign cfg.cfg_ready = cfg_ready_c;
   assign accept        = cfg.cfg_valid & cfg_ready_c;
   assign div_in        = (cfg.cfg_div == '0) ? ONE : cfg.cfg_div;
   assign clk_out       = clk_q;
   assign tick          = tick_q;

   // Per-channel next state: reload/toggle on terminal count, disable handling, cfg capture.
   always_comb begin
      pend_d = pend_q;
      clk_d  = clk_q;
      tick_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]      = cnt_q[i];
         div_act_d[i]  = div_act_q[i];
         div_pend_d[i] = div_pend_q[i];
         div_next[i]   = pend_q[i] ? div_pend_q[i] : div_act_q[i];
         if (!ch_en[i]) begin
            cnt_d[i]     = div_next[i] - ONE;
            clk_d[i]     = 1'b0;
            div_act_d[i] = div_next[i];
            pend_d[i]    = 1'b0;
         end else if (cnt_q[i] == '0) begin
            cnt_d[i]     = div_next[i] - ONE;
            clk_d[i]     = ~clk_q[i];
            tick_d[i]    = ~clk_q[i];
            div_act_d[i] = div_next[i];
            pend_d[i]    = 1'b0;
         end else begin
            cnt_d[i] = cnt_q[i] - ONE;
         end
         // A boundary on this same edge already used the old pending state above.
         if (accept && (cfg.cfg_ch == CH_W'(i))) begin
            div_pend_d[i] = div_in;
            pend_d[i]     = 1'b1;
         end
      end
   end

   // State registers with synchronous reset to the default divisor.
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         pend_q <= '0;
         clk_q  <= '0;
         tick_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]      <= CNT_RST;
            div_act_q[i]  <= DIV_RST;
            div_pend_q[i] <= DIV_RST;
         end
      end else begin
         pend_q <= pend_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]      <= cnt_d[i];
            div_act_q[i]  <= div_act_d[i];
            div_pend_q[i] <= div_pend_d[i];
         end
      end
   end
endmodule
